wb_mem_slave: RTL

Wishbone responder sitting on the far side of the shared bus arbiter: terminates both the data bus (wb_cyc/wb_stb/wb_we/wb_adr/wb_dat_i → wb_dat_o/wb_ack) and the instruction bus (wb_inst_cyc/wb_inst_stb/wb_inst_pc → wb_inst_o/wb_inst_ack). It serves both from one single-port on-chip RAM, arbitrating internally between the two buses. It adds an optional fixed wait-state count and returns one single-cycle ack per transfer.

---
 rtl/wb_mem_slave_pkg.sv | 20 ++
 rtl/wb_mem_ram.sv | 41 ++++
 rtl/wb_mem_slave.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_mem_slave_pkg.sv
// -----------------------------------------------------------------------------
// wb_mem_slave_pkg
// Shared constants for the Wishbone memory responder:
//   - DataWidth / PcWidth : bus data and address widths used across the core
//   - WbMem* states       : FSM encodings for the responder (IDLE / WAIT / ACK)
//   - WbMemOwn*           : which bus currently owns the RAM transfer
// -----------------------------------------------------------------------------
package wb_mem_slave_pkg;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned PcWidth   = 16;

    localparam logic [1:0] WbMemIdle = 2'd0;
    localparam logic [1:0] WbMemWait = 2'd1;
    localparam logic [1:0] WbMemAck  = 2'd2;

    localparam logic WbMemOwnData = 1'b0;
    localparam logic WbMemOwnInst = 1'b1;

endpackage

// File: rtl/wb_mem_ram.sv
// -----------------------------------------------------------------------------
// wb_mem_ram
// Single-port synchronous RAM, DATA_W x 2^DEPTH_LOG2, registered read.
// Contents and the read register are not reset.
// Ports:
//   clk      : clock
//   en_i     : access enable (read or write this edge)
//   we_i     : 1 = write wdata_i, 0 = capture mem[addr_i] into rdata_o
//   addr_i   : word index
//   wdata_i  : write data
//   rdata_o  : read data register, holds its value while en_i = 0
// -----------------------------------------------------------------------------
module wb_mem_ram #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(32'd1 << DEPTH_LOG2) - 32'd1];
    logic [DATA_W-1:0] rdata_q;

    // Storage array and registered read port (read-first is irrelevant: one op per access)
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_mem_slave.sv
// -----------------------------------------------------------------------------
// wb_mem_slave
// Wishbone responder serving a data bus (read/write) and an instruction bus
// (read-only) from one single-port RAM, with round-robin arbitration on ties
// and a one-cycle ack per transfer.
//
// Optional feature macro: WB_MEM_WAIT_EN
//   defined   : WAIT state + counter present, WAIT_CYCLES extra wait states
//   undefined : IDLE goes straight to ACK, latency 1, WAIT_CYCLES ignored
//
// Ports:
//   clk, rst               : clock, asynchronous active-low reset
//   wb_cyc/wb_stb/wb_we    : data bus request and direction
//   wb_adr, wb_dat_i       : data word address, write data
//   wb_dat_o, wb_ack       : read data (valid with ack), one-cycle ack
//   wb_inst_cyc/wb_inst_stb: instruction bus request
//   wb_inst_pc             : instruction word address
//   wb_inst_o, wb_inst_ack : fetched word (valid with ack), one-cycle ack
// -----------------------------------------------------------------------------
module wb_mem_slave
    import wb_mem_slave_pkg::*;
#(
    parameter int unsigned DATA_W      = DataWidth,
    parameter int unsigned ADDR_W      = PcWidth,
    parameter int unsigned DEPTH_LOG2  = 12,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_adr,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic              wb_ack,
    input  logic              wb_inst_cyc,
    input  logic              wb_inst_stb,
    input  logic [ADDR_W-1:0] wb_inst_pc,
    output logic [DATA_W-1:0] wb_inst_o,
    output logic              wb_inst_ack
);

    logic [1:0]            state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_owner_q, last_owner_d;
    logic                  we_q, we_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  ack_data_q, ack_data_d;
    logic                  ack_inst_q, ack_inst_d;

    logic                  req_data_s, req_inst_s, tie_s, grant_inst_s;
    logic                  ram_en_s;
    logic [DATA_W-1:0]     ram_rdata_s;

    // Upper address bits alias onto the RAM and are deliberately ignored.
    logic addr_hi_unused_s;
    assign addr_hi_unused_s = ^{wb_adr[ADDR_W-1:DEPTH_LOG2], wb_inst_pc[ADDR_W-1:DEPTH_LOG2]};

    assign req_data_s = wb_cyc & wb_stb;
    assign req_inst_s = wb_inst_cyc & wb_inst_stb;
    assign tie_s      = req_data_s & req_inst_s;
    // last_owner only records the winner of contested grants; a lone requester
    // always wins and does not disturb the round-robin history.
    assign grant_inst_s = req_inst_s & (~req_data_s | (last_owner_q == WbMemOwnData));

`ifdef WB_MEM_WAIT_EN
    localparam logic [3:0] WaitLoad = (WAIT_CYCLES > 32'd15) ? 4'd15 : 4'(WAIT_CYCLES);

    logic [3:0] cnt_q, cnt_d;
    logic       owner_req_s;

    assign owner_req_s = (owner_q == WbMemOwnInst) ? req_inst_s : req_data_s;
`else
    logic wait_cfg_unused_s;
    assign wait_cfg_unused_s = (WAIT_CYCLES != 32'd0);
`endif

    // Next-state logic: arbitration in IDLE, wait counting / abort, ACK back to IDLE
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
`ifdef WB_MEM_WAIT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            WbMemIdle: begin
                if (req_data_s | req_inst_s) begin
                    owner_d = grant_inst_s ? WbMemOwnInst : WbMemOwnData;
                    if (tie_s) begin
                        last_owner_d = grant_inst_s ? WbMemOwnInst : WbMemOwnData;
                    end else begin
                        last_owner_d = last_owner_q;
                    end
                    we_d    = grant_inst_s ? 1'b0 : wb_we;
                    idx_d   = grant_inst_s ? wb_inst_pc[DEPTH_LOG2-1:0] : wb_adr[DEPTH_LOG2-1:0];
                    wdata_d = wb_dat_i;
`ifdef WB_MEM_WAIT_EN
                    if (WaitLoad != 4'd0) begin
                        state_d = WbMemWait;
                        cnt_d   = WaitLoad;
                    end else begin
                        state_d = WbMemAck;
                        cnt_d   = 4'd0;
                    end
`else
                    state_d = WbMemAck;
`endif
                end else begin
                    state_d = WbMemIdle;
                end
            end
`ifdef WB_MEM_WAIT_EN
            WbMemWait: begin
                if (!owner_req_s) begin
                    // Owner withdrew: no ack and nothing written.
                    state_d = WbMemIdle;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d = WbMemAck;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = WbMemWait;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
`endif
            WbMemAck: begin
                state_d = WbMemIdle;
            end
            default: begin
                state_d = WbMemIdle;
            end
        endcase
    end

    // The RAM is touched only on the edge that enters ACK, so the registered
    // read data lands together with the ack and aborted writes never commit.
    assign ram_en_s   = (state_d == WbMemAck);
    assign ack_data_d = ram_en_s & (owner_d == WbMemOwnData);
    assign ack_inst_d = ram_en_s & (owner_d == WbMemOwnInst);

    wb_mem_ram #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en_s),
        .we_i    (we_d),
        .addr_i  (idx_d),
        .wdata_i (wdata_d),
        .rdata_o (ram_rdata_s)
    );

    // FSM and transfer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= WbMemIdle;
            owner_q      <= WbMemOwnData;
            last_owner_q <= WbMemOwnInst;
            we_q         <= 1'b0;
            idx_q        <= {DEPTH_LOG2{1'b0}};
            wdata_q      <= {DATA_W{1'b0}};
            ack_data_q   <= 1'b0;
            ack_inst_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            ack_data_q   <= ack_data_d;
            ack_inst_q   <= ack_inst_d;
        end
    end

`ifdef WB_MEM_WAIT_EN
    // Wait-state counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Outputs come straight from registers; the RAM read register is steered
    // only to the owning port and only during its (read) ack.
    assign wb_ack      = ack_data_q;
    assign wb_inst_ack = ack_inst_q;
    assign wb_dat_o    = (ack_data_q & ~we_q) ? ram_rdata_s : {DATA_W{1'b0}};
    assign wb_inst_o   = ack_inst_q ? ram_rdata_s : {DATA_W{1'b0}};

endmodule
